laser_host: RTL and testbench

LASER_HOST -- requirements
Module: laser_host

---
 rtl/laser_host_pkg.sv | 18 +
 rtl/laser_pt_buf.sv | 29 ++
 rtl/laser_host.sv | 153 +++++++++++++++
 tb/tb_laser_host.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/laser_host_pkg.sv
// Shared definitions for the laser host slice: FSM encoding and datapath widths.
package laser_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_STREAM,
    S_WAIT,
    S_RESULT
  } state_t;

  localparam int unsigned NPTS_DEF = 40;
  localparam int unsigned COORD_W  = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned PT_W     = 2 * COORD_W;

endpackage

// File: rtl/laser_pt_buf.sv
// Point buffer: one synchronous write port, one combinational read port; not reset.
module laser_pt_buf
  import laser_host_pkg::*;
#(
  parameter int unsigned NPTS = NPTS_DEF
) (
  input  logic              CLK,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [PT_W-1:0]   i_wdata,
  input  logic [ADDR_W-1:0] i_ridx,
  output logic [PT_W-1:0]   o_rdata
);

  logic [PT_W-1:0] r_mem [NPTS];

  always_ff @(posedge CLK) begin
    if (i_we && (i_waddr < ADDR_W'(NPTS)))
      r_mem[i_waddr] <= i_wdata;
  end

  // The host reads one slot past the end on the last stream cycle; return zero there.
  always_comb begin
    o_rdata = '0;
    if (i_ridx < ADDR_W'(NPTS))
      o_rdata = r_mem[i_ridx];
  end

endmodule

// File: rtl/laser_host.sv
// Laser host: replays the point buffer into the circle-solver core and captures its result.
module laser_host
  import laser_host_pkg::*;
#(
  parameter int unsigned NPTS    = NPTS_DEF,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               start,
  output logic               core_rst,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  input  logic               DONE,
  output logic               busy,
  output logic               res_valid,
  output logic [COORD_W-1:0] res_c1x,
  output logic [COORD_W-1:0] res_c1y,
  output logic [COORD_W-1:0] res_c2x,
  output logic [COORD_W-1:0] res_c2y,
  output logic [CNT_W-1:0]   res_cycles,
  output logic               err_timeout
);

  state_t             r_state;
  logic               r_crst;
  logic [ADDR_W-1:0]  r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_core_rst;
  logic [COORD_W-1:0] r_x, r_y;
  logic               r_busy, r_res_valid, r_err;
  logic [COORD_W-1:0] r_c1x, r_c1y, r_c2x, r_c2y;
  logic [CNT_W-1:0]   r_cycles;
  logic               w_wr_ok;
  logic [PT_W-1:0]    w_rd;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_wr_ok   = wr_en && (r_state == S_IDLE) && (wr_addr < ADDR_W'(NPTS));
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  laser_pt_buf #(.NPTS(NPTS)) u_buf (
    .CLK     (CLK),
    .i_we    (w_wr_ok),
    .i_waddr (wr_addr),
    .i_wdata ({wr_x, wr_y}),
    .i_ridx  (r_idx),
    .o_rdata (w_rd)
  );

  // r_idx runs one ahead of the point on X/Y so the registered outputs carry buf[k] in stream cycle k.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_crst      <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_core_rst  <= 1'b1;
      r_x         <= '0;
      r_y         <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_c1x       <= '0;
      r_c1y       <= '0;
      r_c2x       <= '0;
      r_c2y       <= '0;
      r_cycles    <= '0;
    end else begin
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CRST;
            r_busy  <= 1'b1;
            r_crst  <= 1'b0;
            r_idx   <= '0;
          end
        end
        S_CRST: begin
          if (r_crst) begin
            r_state    <= S_STREAM;
            r_core_rst <= 1'b0;
            {r_x, r_y} <= w_rd;
            r_idx      <= r_idx + ADDR_W'(1);
            r_cnt      <= '0;
          end else begin
            r_crst <= 1'b1;
          end
        end
        S_STREAM: begin
          r_cnt <= w_cnt_inc;
          if (r_idx == ADDR_W'(NPTS)) begin
            r_state <= S_WAIT;
            r_x     <= '0;
            r_y     <= '0;
          end else begin
            {r_x, r_y} <= w_rd;
            r_idx      <= r_idx + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (DONE) begin
            r_state     <= S_RESULT;
            r_c1x       <= C1X;
            r_c1y       <= C1Y;
            r_c2x       <= C2X;
            r_c2y       <= C2Y;
            r_cycles    <= r_cnt;
            r_res_valid <= 1'b1;
            r_core_rst  <= 1'b1;
          end else if (r_cnt >= CNT_W'(TIMEOUT)) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        S_RESULT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_core_rst <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst    = r_core_rst;
  assign X           = r_x;
  assign Y           = r_y;
  assign busy        = r_busy;
  assign res_valid   = r_res_valid;
  assign err_timeout = r_err;
  assign res_c1x     = r_c1x;
  assign res_c1y     = r_c1y;
  assign res_c2x     = r_c2x;
  assign res_c2y     = r_c2y;
  assign res_cycles  = r_cycles;

endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host: streaming order, result capture, timeout, ignored inputs, mid-run reset.
module tb_laser_host;

  localparam int NPTS    = 40;
  localparam int TIMEOUT = 200;

  logic        CLK, RST, wr_en, start, DONE;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_x, wr_y, C1X, C1Y, C2X, C2Y;
  logic        core_rst, busy, res_valid, err_timeout;
  logic [3:0]  X, Y, res_c1x, res_c1y, res_c2x, res_c2y;
  logic [15:0] res_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  laser_host #(.NPTS(NPTS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .start(start), .core_rst(core_rst), .X(X), .Y(Y),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
    .busy(busy), .res_valid(res_valid),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .res_cycles(res_cycles), .err_timeout(err_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  // Start a run; returns in the first STREAM cycle (t0).
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("crst1_rst", 32'(core_rst), 32'd1);
    check_val("crst1_busy", 32'(busy), 32'd1);
    tick();
    check_val("crst2_rst", 32'(core_rst), 32'd1);
    tick();
    check_val("stream_first_rst", 32'(core_rst), 32'd0);
  endtask

  // Points were loaded as i -> (i%16, i/16).
  task automatic stream_chk(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      check_val($sformatf("pt%0d_x", k), 32'(X), 32'(k % 16));
      check_val($sformatf("pt%0d_y", k), 32'(Y), 32'(k / 16));
      check_val($sformatf("pt%0d_rst", k), 32'(core_rst), 32'd0);
      if (k < to) tick();
    end
  endtask

  task automatic check_wait_entry();
    check_val("wait_x", 32'(X), 32'd0);
    check_val("wait_y", 32'(Y), 32'd0);
    check_val("wait_rst", 32'(core_rst), 32'd0);
    check_val("wait_busy", 32'(busy), 32'd1);
  endtask

  task automatic check_res(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [15:0] cyc);
    check_val("res_c1x", 32'(res_c1x), 32'(a));
    check_val("res_c1y", 32'(res_c1y), 32'(b));
    check_val("res_c2x", 32'(res_c2x), 32'(c));
    check_val("res_c2y", 32'(res_c2y), 32'(d));
    check_val("res_cycles", 32'(res_cycles), 32'(cyc));
  endtask

  initial begin
    RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
    start = 1'b0; DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    wait_n(2);
    check_val("rst_core_rst", 32'(core_rst), 32'd1);
    check_val("rst_x", 32'(X), 32'd0);
    check_val("rst_y", 32'(Y), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_err", 32'(err_timeout), 32'd0);
    check_res(4'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < NPTS; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_x = 4'(i % 16); wr_y = 4'(i / 16);
      tick();
    end
    wr_en = 1'b0;

    // Run 1: DONE 100 cycles after point 0.
    start_run();
    stream_chk(0, 39);
    tick();
    check_wait_entry();
    wait_n(60);
    check_val("r1_no_valid_yet", 32'(res_valid), 32'd0);
    C1X = 4'd3; C1Y = 4'd4; C2X = 4'd11; C2Y = 4'd12; DONE = 1'b1;
    tick();
    DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    check_val("r1_res_valid", 32'(res_valid), 32'd1);
    check_val("r1_result_rst", 32'(core_rst), 32'd1);
    check_val("r1_result_busy", 32'(busy), 32'd1);
    check_res(4'd3, 4'd4, 4'd11, 4'd12, 16'd100);
    tick();
    check_val("r1_valid_pulse", 32'(res_valid), 32'd0);
    check_val("r1_idle_busy", 32'(busy), 32'd0);
    check_res(4'd3, 4'd4, 4'd11, 4'd12, 16'd100);

    // Run 2: no DONE, timeout once the counter reaches 200.
    start_run();
    stream_chk(0, 39);
    tick();
    check_wait_entry();
    wait_n(160);
    check_val("r2_err_early", 32'(err_timeout), 32'd0);
    check_val("r2_busy_before", 32'(busy), 32'd1);
    tick();
    check_val("r2_err", 32'(err_timeout), 32'd1);
    check_val("r2_busy", 32'(busy), 32'd0);
    check_val("r2_rst", 32'(core_rst), 32'd1);
    check_val("r2_no_valid", 32'(res_valid), 32'd0);
    check_res(4'd3, 4'd4, 4'd11, 4'd12, 16'd100);
    tick();
    check_val("r2_err_pulse", 32'(err_timeout), 32'd0);

    // Run 3: start and DONE during STREAM, write during WAIT are ignored.
    start_run();
    stream_chk(0, 5);
    start = 1'b1; DONE = 1'b1;
    tick();
    start = 1'b0; DONE = 1'b0;
    check_val("r3_stream_done_ignored", 32'(res_valid), 32'd0);
    stream_chk(6, 39);
    tick();
    check_wait_entry();
    wr_en = 1'b1; wr_addr = 6'd5; wr_x = 4'd15; wr_y = 4'd15;
    tick();
    wr_en = 1'b0;
    wait_n(9);
    C1X = 4'd1; C1Y = 4'd2; C2X = 4'd5; C2Y = 4'd6; DONE = 1'b1;
    tick();
    DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    check_val("r3_res_valid", 32'(res_valid), 32'd1);
    check_res(4'd1, 4'd2, 4'd5, 4'd6, 16'd50);
    tick();

    // IDLE: out-of-range write and stray DONE.
    wr_en = 1'b1; wr_addr = 6'd45; wr_x = 4'd15; wr_y = 4'd15;
    tick();
    wr_en = 1'b0;
    C1X = 4'd9; C1Y = 4'd9; C2X = 4'd9; C2Y = 4'd9; DONE = 1'b1;
    tick();
    DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    check_val("idle_done_ignored", 32'(res_valid), 32'd0);
    check_res(4'd1, 4'd2, 4'd5, 4'd6, 16'd50);
    tick();

    // Run 4: buf[5] intact; reset at stream index 20.
    start_run();
    stream_chk(0, 20);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_val("mrst_rst", 32'(core_rst), 32'd1);
    check_val("mrst_x", 32'(X), 32'd0);
    check_val("mrst_y", 32'(Y), 32'd0);
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_valid", 32'(res_valid), 32'd0);
    check_val("mrst_err", 32'(err_timeout), 32'd0);
    tick();
    check_val("mrst_idle_busy", 32'(busy), 32'd0);
    check_val("mrst_idle_err", 32'(err_timeout), 32'd0);

    // Run 5: full replay from point 0 after the abort.
    start_run();
    stream_chk(0, 39);
    tick();
    check_wait_entry();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
